// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared encodings, FSM states and alignment helpers for the DM access sequencer
package dm_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough to count the largest supported read latency (4 cycles).
  localparam int LAT_CW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] r;
    r = off;
    if (size == SZ_HALF) r = {off[1], 1'b0};
    else if (size == SZ_WORD) r = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - combinational store lane merge and load lane extract with sign/zero extension
module dm_lane_unit
  import dm_ctrl_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = old_word[{offset, 3'b000} +: 8];
  assign sel_half = old_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{offset, 3'b000} +: 8]     = new_data[7:0];
      SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: extracted = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      SZ_HALF: extracted = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      default: extracted = old_word;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - sequencer for word/half/byte loads and read-modify-write stores on a single DM port
// Optional misalignment trap enabled by defining DM_MISALIGN_TRAP_EN.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-3:0] dm_addr,
  output logic          dm_re,
  output logic          dm_we,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata
);

  state_t state, state_d;

  logic [LAT_CW-1:0] cnt;
  logic [AW-1:0]     addr_q;
  logic [1:0]        size_q;
  logic              we_q, uns_q, err_q;
  logic [31:0]       wdata_q, word_q, rdata_q;

  logic [1:0]  req_sz, req_off;
  logic        trap, lat_done;
  logic [31:0] old_word, merged, extracted;

  // Reserved size encoding behaves as a word access.
  assign req_sz   = (req_size == SZ_BYTE || req_size == SZ_HALF) ? req_size : SZ_WORD;
  assign lat_done = (cnt == LAT_CW'(RD_LAT - 1));

`ifdef DM_MISALIGN_TRAP_EN
  assign trap    = is_misaligned(req_sz, req_addr[1:0]);
  assign req_off = req_addr[1:0];
`else
  assign trap    = 1'b0;
  assign req_off = align_off(req_sz, req_addr[1:0]);
`endif

  // In the last WAIT cycle the word comes straight from DM; during WR it comes from the capture register.
  assign old_word = (state == S_WAIT) ? dm_rdata : word_q;

  dm_lane_unit u_lane (
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .old_word    (old_word),
    .new_data    (wdata_q),
    .merged      (merged),
    .extracted   (extracted)
  );

  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    dm_re     = 1'b0;
    dm_we     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (trap)                          state_d = S_RESP;
          else if (req_we && req_sz == SZ_WORD) state_d = S_WR;
          else                               state_d = S_RD;
        end
      end
      S_RD: begin
        dm_re   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (lat_done) state_d = we_q ? S_WR : S_RESP;
      S_WR: begin
        dm_we   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q  <= {req_addr[AW-1:2], req_off};
          size_q  <= req_sz;
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          wdata_q <= req_wdata;
          err_q   <= trap;
          rdata_q <= '0;
        end
        S_RD: cnt <= '0;
        S_WAIT: begin
          if (lat_done) begin
            word_q <= dm_rdata;
            if (!we_q) rdata_q <= extracted;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dm_addr   = addr_q[AW-1:2];
  assign dm_wdata  = (state == S_WR) ? merged : 32'h0;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - directed and randomized bench for dm_access_ctrl against a behavioural memory model
module tb_dm_access_ctrl;

  localparam int RD_LAT = 1;
  localparam int AW     = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-3:0] dm_addr;
  logic          dm_re, dm_we;
  logic [31:0]   dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  dm_access_ctrl #(.RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Data memory with RD_LAT-cycle read pipeline; data is poisoned outside the valid cycle.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  rd_addr_p [RD_LAT];
  logic        rd_vld_p [RD_LAT];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    rd_addr_p[0] <= dm_addr;
    rd_vld_p[0]  <= dm_re;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_addr_p[i] <= rd_addr_p[i-1];
      rd_vld_p[i]  <= rd_vld_p[i-1];
    end
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
    end
  end

  assign dm_rdata = rd_vld_p[RD_LAT-1] ? mem[rd_addr_p[RD_LAT-1]] : 32'hBAD0BAD0;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [31:0] last_rsp;
  logic        last_err;
  logic [7:0]  last_wa;
  logic [31:0] last_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the access rules: byte masks, shifts and fixed latencies.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_err,
                       output int e_lat, output int e_re, output int e_we);
    int s, off, idx, width;
    logic mis;
    logic [31:0] old, mask, v;
    s     = (sz == 2'b11) ? 2 : int'(sz);
    off   = int'(addr[1:0]);
    idx   = int'(addr[9:2]);
    e_rd  = 32'h0;
    e_err = 1'b0;
    mis   = (s == 1 && (off % 2) != 0) || (s == 2 && off != 0);
`ifdef DM_MISALIGN_TRAP_EN
    if (mis) begin
      e_err = 1'b1; e_lat = 1; e_re = 0; e_we = 0;
      return;
    end
`else
    if (mis) off = (s == 1) ? off - (off % 2) : 0;
`endif
    old   = ref_mem[idx];
    width = (s == 0) ? 8 : 16;
    mask  = (32'h1 << width) - 32'h1;
    if (we) begin
      if (s == 2) begin
        ref_mem[idx] = wd;
        e_lat = 2; e_re = 0; e_we = 1;
      end else begin
        ref_mem[idx] = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        e_lat = RD_LAT + 3; e_re = 1; e_we = 1;
      end
    end else begin
      if (s == 2) v = old;
      else begin
        v = (old >> (8 * off)) & mask;
        if (!uns && v[width-1]) v = v | ~mask;
      end
      e_rd = v;
      e_lat = RD_LAT + 2; e_re = 1; e_we = 0;
    end
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wd, input int hold);
    logic [31:0] e_rd, held;
    logic        e_err;
    int          e_lat, e_re, e_we, lat, re_cnt, we_cnt;
    model(we, sz, uns, addr, wd, e_rd, e_err, e_lat, e_re, e_we);
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; re_cnt = 0; we_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      re_cnt += int'(dm_re);
      we_cnt += int'(dm_we);
      if (dm_we) begin last_wa = dm_addr; last_wd = dm_wdata; end
    end while (!rsp_valid && lat < 40);
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".rsp_rdata"}, rsp_rdata, e_rd);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(e_err));
    held = rsp_rdata;
    last_rsp = rsp_rdata;
    last_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, held);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      re_cnt += int'(dm_re);
      we_cnt += int'(dm_we);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".dm_re_count"}, 32'(re_cnt), 32'(e_re));
    chk({tag, ".dm_we_count"}, 32'(we_cnt), 32'(e_we));
    chk({tag, ".dm_word"}, mem[addr[9:2]], ref_mem[addr[9:2]]);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int we_seen;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    last_wa = '0; last_wd = '0; last_rsp = '0; last_err = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.dm_re", 32'(dm_re), 32'd0);
    chk("reset.dm_we", 32'(dm_we), 32'd0);
    chk("reset.dm_addr", 32'(dm_addr), 32'h0);
    chk("reset.dm_wdata", dm_wdata, 32'h0);
    rst_n = 1'b1;

    run_op("word_store", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 0);
    chk("word_store.dm_addr", 32'(last_wa), 32'h04);
    chk("word_store.dm_wdata", last_wd, 32'hDEADBEEF);
    run_op("word_setup", 1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344, 0);
    run_op("byte_store", 1'b1, 2'b00, 1'b0, 10'h012, 32'h000000AB, 0);
    chk("byte_store.dm_wdata", last_wd, 32'h11AB3344);
    run_op("ld_sbyte", 1'b0, 2'b00, 1'b0, 10'h012, 32'h0, 0);
    chk("ld_sbyte.value", last_rsp, 32'hFFFFFFAB);
    run_op("ld_ubyte", 1'b0, 2'b00, 1'b1, 10'h012, 32'h0, 0);
    chk("ld_ubyte.value", last_rsp, 32'h000000AB);
    run_op("ld_shalf", 1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 0);
    chk("ld_shalf.value", last_rsp, 32'h000011AB);
    run_op("backpressure", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 5);
    chk("backpressure.value", last_rsp, 32'h11AB3344);

    // Abort a half store while it waits for read data.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 10'h010; req_wdata = 32'h00005555; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.dm_we", 32'(dm_we), 32'd0);
    chk("abort.dm_re", 32'(dm_re), 32'd0);
    chk("abort.req_ready_in_reset", 32'(req_ready), 32'd1);
    we_seen = 0;
    repeat (2) begin @(negedge clk); we_seen += int'(dm_we); end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); we_seen += int'(dm_we); end
    chk("abort.we_seen", 32'(we_seen), 32'd0);
    chk("abort.req_ready", 32'(req_ready), 32'd1);
    chk("abort.dm_word", mem[8'h04], 32'h11AB3344);

    run_op("misalign_half", 1'b1, 2'b01, 1'b0, 10'h013, 32'h0000CAFE, 0);
`ifdef DM_MISALIGN_TRAP_EN
    chk("misalign_half.err", 32'(last_err), 32'd1);
    chk("misalign_half.word_kept", mem[8'h04], 32'h11AB3344);
`else
    chk("misalign_half.err", 32'(last_err), 32'd0);
    chk("misalign_half.upper_half", mem[8'h04], 32'hCAFE3344);
`endif

    for (int n = 0; n < 60; n++) begin
      run_op("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
